// File: rtl/chunked_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin computed CHUNK bits per clock, with the
// inter-chunk carry held in a register. Operands in and result out via valid/ready.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and outputs hold while
    // out_valid waits for out_ready.

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDX_W'(i)) sum[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    end
                    carry_reg <= chunk_sum[CHUNK];
                    if (idx == LAST_IDX) begin
                        // The last chunk holds the sign bit, so its MSB is the result sign.
                        idx      <= '0;
                        cout     <= chunk_sum[CHUNK];
                        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four instances (CHUNK = 4, 16, 1, 8) exercised in turn,
// results checked against an arithmetic reference through an expected-result queue.
`timescale 1ns/1ps
module tb_chunked_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_v  [4];
    logic         in_ready_v  [4];
    logic [W-1:0] a_v         [4];
    logic [W-1:0] b_v         [4];
    logic         cin_v       [4];
    logic         out_valid_v [4];
    logic         out_ready_v [4];
    logic [W-1:0] sum_v       [4];
    logic         cout_v      [4];
    logic         ovf_v       [4];

    chunked_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]));
    chunked_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .overflow(ovf_v[1]));
    chunked_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .overflow(ovf_v[2]));
    chunked_adder #(.WIDTH(W), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready_v[3]), .sum(sum_v[3]), .cout(cout_v[3]), .overflow(ovf_v[3]));

    int checks   = 0;
    int failures = 0;
    int cfg      = 0;
    // Packed as {overflow, cout, sum}.
    logic [W+1:0] exp_q[$];

    function automatic int n_of(input int c);
        case (c)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        int unsigned total;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        total = int'(a) + int'(b) + int'(ci);
        s  = total[W-1:0];
        co = (total >= 65536);
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ov, co, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg=%0d: got %0h expected %0h at %0t", name, cfg, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected result per completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid_v[cfg] && out_ready_v[cfg]) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output cfg=%0d: got %0h with no result pending",
                         cfg, {ovf_v[cfg], cout_v[cfg], sum_v[cfg]});
            end else begin
                check("result", 32'({ovf_v[cfg], cout_v[cfg], sum_v[cfg]}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W+1:0] exp, input int hold,
                         input bit noise);
        int budget;
        int lat;
        budget = 0;
        while (!in_ready_v[c] && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready_v[c]) check("in_ready_timeout", 32'(in_ready_v[c]), 32'd1);
        in_valid_v[c] = 1'b1;
        a_v[c]        = a;
        b_v[c]        = b;
        cin_v[c]      = ci;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid_v[c] = 1'b0;
        lat = 0;
        while (!out_valid_v[c] && lat < 64) begin
            if (noise) begin
                in_valid_v[c] = 1'($urandom_range(0, 1));
                a_v[c]        = 16'($urandom_range(0, 65535));
                b_v[c]        = 16'($urandom_range(0, 65535));
                cin_v[c]      = 1'($urandom_range(0, 1));
            end
            out_ready_v[c] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid_v[c]  = 1'b0;
        out_ready_v[c] = (hold == 0);
        check("latency", 32'(lat), 32'(n_of(c)));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid_v[c]), 32'd1);
            check("hold_result", 32'({ovf_v[c], cout_v[c], sum_v[c]}), 32'(exp));
            @(posedge clk); #1;
        end
        out_ready_v[c] = 1'b1;
        @(posedge clk); #1;
        check("release_valid", 32'(out_valid_v[c]), 32'd0);
        check("release_ready", 32'(in_ready_v[c]), 32'd1);
        out_ready_v[c] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int c, input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_v[c]), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid_v[c]), 32'd0);
        check({tag, "_outputs"}, 32'({ovf_v[c], cout_v[c], sum_v[c]}), 32'd0);
    endtask

    task automatic reset_mid_run;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b1;
        a_v[0]        = 16'h1111;
        b_v[0]        = 16'h2222;
        cin_v[0]      = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_output", 32'(out_valid_v[0]), 32'd0);
        end
        out_ready_v[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid_v[c]  = 1'b0;
            a_v[c]         = '0;
            b_v[c]         = '0;
            cin_v[c]       = 1'b0;
            out_ready_v[c] = 1'b0;
        end
        #1;
        for (int c = 0; c < 4; c++) check_reset_outputs(c, "reset");
        #20;
        @(negedge clk);
        rst = 1'b0;

        cfg = 0;
        do_op(0, 16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002}, 0, 1'b0);
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, 0, 1'b0);
        do_op(0, 16'hAAAA, 16'h5555, 1'b1, {1'b0, 1'b1, 16'h0000}, 0, 1'b0);
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, 0, 1'b0);
        do_op(0, 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000}, 0, 1'b0);
        do_op(0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 5, 1'b0);
        do_op(0, 16'h00F0, 16'h0F0F, 1'b1, {1'b0, 1'b0, 16'h1000}, 2, 1'b1);
        reset_mid_run();
        do_op(0, 16'h0003, 16'h0004, 1'b0, {1'b0, 1'b0, 16'h0007}, 0, 1'b0);

        for (int c = 0; c < 4; c++) begin
            cfg = c;
            for (int k = 0; k < 1000; k++) begin
                logic [W-1:0] ra;
                logic [W-1:0] rb;
                logic         rc;
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
                rc = 1'($urandom_range(0, 1));
                do_op(c, ra, rb, rc, model(ra, rb, rc), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
